// File: rtl/obi_wb_arbiter.sv
// Arbitrates the OBI instruction and data ports onto one classic Wishbone master, one transfer at a time.
// Optional ARB_ROUND_ROBIN_EN selects round-robin arbitration; otherwise data has fixed priority.
module obi_wb_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    instr_req_i,
    output logic                    instr_gnt_o,
    input  logic [ADDR_WIDTH-1:0]   instr_addr_i,
    output logic                    instr_rvalid_o,
    output logic [DATA_WIDTH-1:0]   instr_rdata_o,
    input  logic                    data_req_i,
    output logic                    data_gnt_o,
    input  logic                    data_we_i,
    input  logic [DATA_WIDTH/8-1:0] data_be_i,
    input  logic [ADDR_WIDTH-1:0]   data_addr_i,
    input  logic [DATA_WIDTH-1:0]   data_wdata_i,
    output logic                    data_rvalid_o,
    output logic [DATA_WIDTH-1:0]   data_rdata_o,
    output logic                    data_err_o,
    output logic                    wb_cyc_o,
    output logic                    wb_stb_o,
    output logic                    wb_we_o,
    output logic [DATA_WIDTH/8-1:0] wb_sel_o,
    output logic [ADDR_WIDTH-1:0]   wb_addr_o,
    output logic [DATA_WIDTH-1:0]   wb_data_o,
    input  logic [DATA_WIDTH-1:0]   wb_data_i,
    input  logic                    wb_ack_i,
    output logic                    timeout_o
);
    localparam int BW = DATA_WIDTH / 8;
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] TLIM = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

    state_t                  state_q;
    logic                    src_data_q;
    logic                    cyc_q;
    logic                    we_q;
    logic [BW-1:0]           sel_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [CW-1:0]           cnt_q;
    logic                    instr_rvalid_q;
    logic                    data_rvalid_q;
    logic [DATA_WIDTH-1:0]   instr_rdata_q;
    logic [DATA_WIDTH-1:0]   data_rdata_q;
    logic                    data_err_q;
    logic                    timeout_q;
    logic                    pick_data;
    logic                    tmo_hit;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_data_q;
    always_comb pick_data = data_req_i && (!instr_req_i || !last_data_q);
`else
    always_comb pick_data = data_req_i;
`endif

    // Grants are gated by reset so the core never sees a grant while the block is held in reset.
    always_comb begin
        instr_gnt_o = rst_ni && (state_q == IDLE) && instr_req_i && !pick_data;
        data_gnt_o  = rst_ni && (state_q == IDLE) && pick_data;
        tmo_hit     = (TIMEOUT_CYCLES != 0) && (cnt_q == TLIM);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= IDLE;
            src_data_q     <= 1'b0;
            cyc_q          <= 1'b0;
            we_q           <= 1'b0;
            sel_q          <= '0;
            addr_q         <= '0;
            wdata_q        <= '0;
            cnt_q          <= '0;
            instr_rvalid_q <= 1'b0;
            data_rvalid_q  <= 1'b0;
            instr_rdata_q  <= '0;
            data_rdata_q   <= '0;
            data_err_q     <= 1'b0;
            timeout_q      <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            last_data_q    <= 1'b0;
`endif
        end else begin
            instr_rvalid_q <= 1'b0;
            data_rvalid_q  <= 1'b0;
            timeout_q      <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (instr_gnt_o || data_gnt_o) begin
                        src_data_q <= data_gnt_o;
                        cyc_q      <= 1'b1;
                        state_q    <= BUS;
`ifdef ARB_ROUND_ROBIN_EN
                        last_data_q <= data_gnt_o;
`endif
                        if (data_gnt_o) begin
                            addr_q  <= data_addr_i;
                            we_q    <= data_we_i;
                            sel_q   <= data_be_i;
                            wdata_q <= data_wdata_i;
                        end else begin
                            addr_q  <= instr_addr_i;
                            we_q    <= 1'b0;
                            sel_q   <= '1;
                            wdata_q <= '0;
                        end
                    end
                end
                BUS: begin
                    cnt_q <= cnt_q + 1'b1;
                    // Ack is tested first so it wins over a coincident watchdog expiry.
                    if (wb_ack_i || tmo_hit) begin
                        cyc_q     <= 1'b0;
                        state_q   <= RESP;
                        timeout_q <= !wb_ack_i;
                        if (src_data_q) begin
                            data_rvalid_q <= 1'b1;
                            data_rdata_q  <= wb_ack_i ? wb_data_i : '0;
                            data_err_q    <= !wb_ack_i;
                        end else begin
                            instr_rvalid_q <= 1'b1;
                            instr_rdata_q  <= wb_ack_i ? wb_data_i : '0;
                        end
                    end
                end
                RESP: begin
                    cnt_q   <= '0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign wb_cyc_o       = cyc_q;
    assign wb_stb_o       = cyc_q;
    assign wb_we_o        = we_q;
    assign wb_sel_o       = sel_q;
    assign wb_addr_o      = addr_q;
    assign wb_data_o      = wdata_q;
    assign instr_rvalid_o = instr_rvalid_q;
    assign instr_rdata_o  = instr_rdata_q;
    assign data_rvalid_o  = data_rvalid_q;
    assign data_rdata_o   = data_rdata_q;
    assign data_err_o     = data_err_q;
    assign timeout_o      = timeout_q;
endmodule
